// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard shared constants.
// Used by the register file, its scoreboard and the write/issue decoders.
package regfile_scoreboard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NREG = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W = 6;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_scoreboard_dec.sv
// 5-to-32 one-hot decoder.
// Shared by the writeback select and the issue select.
module regfile_scoreboard_dec
  import regfile_scoreboard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  output logic [NREG-1:0]      onehot
);
  always_comb begin
    onehot = '0;
    onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [4:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              busy_A,
  output logic              busy_B,
  output logic [5:0]        busy_count
);
  import regfile_scoreboard_pkg::REG_IDX_W;
  import regfile_scoreboard_pkg::NREG;
  import regfile_scoreboard_pkg::CNT_W;
  import regfile_scoreboard_pkg::REG_ZERO;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NREG-1:0]   wr_oh;
  logic [NREG-1:0]   iss_oh;

  regfile_scoreboard_dec u_wr_dec (
    .idx    (ctrl_writeReg),
    .onehot (wr_oh)
  );

  regfile_scoreboard_dec u_iss_dec (
    .idx    (issue_rd),
    .onehot (iss_oh)
  );

  // Issue beats writeback: a newer producer is still in flight.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < NREG; i++) begin
      if (issue_valid && iss_oh[i])
        busy_nxt[i] = 1'b1;
      else if (ctrl_writeEnable && wr_oh[i])
        busy_nxt[i] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (ctrl_writeEnable && wr_oh[i])
          regs[i] <= data_writeReg;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;
  logic iss_a, iss_b;

  assign fwd_a = !ctrl_reset && ctrl_writeEnable
               && ctrl_writeReg == ctrl_readRegA
               && ctrl_readRegA != REG_ZERO;
  assign fwd_b = !ctrl_reset && ctrl_writeEnable
               && ctrl_writeReg == ctrl_readRegB
               && ctrl_readRegB != REG_ZERO;
  assign iss_a = issue_valid && issue_rd == ctrl_readRegA;
  assign iss_b = issue_valid && issue_rd == ctrl_readRegB;

  assign data_readRegA = fwd_a ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = fwd_b ? data_writeReg : regs[ctrl_readRegB];
  assign busy_A = busy[ctrl_readRegA] && !(fwd_a && !iss_a);
  assign busy_B = busy[ctrl_readRegB] && !(fwd_b && !iss_b);
`else
  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];
  assign busy_A = busy[ctrl_readRegA];
  assign busy_B = busy[ctrl_readRegB];
`endif

  logic unused_ok;
  assign unused_ok = ^{REG_IDX_W};
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed cases plus random traffic
// checked against an array-based model of the register/busy rules.
module tb_regfile_scoreboard;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        we;
  logic [4:0]  wr, ra, rb, ir;
  logic [31:0] wd;
  logic        iv;
  logic [31:0] rda, rdb;
  logic        ba, bb;
  logic [5:0]  bc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clock = ~clock;

  regfile_scoreboard dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (rda),
    .data_readRegB    (rdb),
    .issue_valid      (iv),
    .issue_rd         (ir),
    .busy_A           (ba),
    .busy_B           (bb),
    .busy_count       (bc)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic [4:0] idx);
    if (ctrl_reset) return 32'd0;
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return m_mem[idx];
  endfunction

  function automatic logic [31:0] exp_busy(logic [4:0] idx);
    if (ctrl_reset || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == idx && !(iv && ir == idx)) return 32'd0;
`endif
    return {31'd0, m_busy[idx]};
  endfunction

  function automatic logic [31:0] exp_cnt();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_busy[i] ? 1 : 0;
    return 32'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".rdA"}, rda, exp_rd(ra));
    chk({tag, ".rdB"}, rdb, exp_rd(rb));
    chk({tag, ".bA"}, {31'd0, ba}, exp_busy(ra));
    chk({tag, ".bB"}, {31'd0, bb}, exp_busy(rb));
    chk({tag, ".cnt"}, {26'd0, bc}, exp_cnt());
  endtask

  task automatic drive(logic w, logic [4:0] wi, logic [31:0] d,
                       logic v, logic [4:0] ii,
                       logic [4:0] a, logic [4:0] b);
    we = w; wr = wi; wd = d; iv = v; ir = ii; ra = a; rb = b;
  endtask

  // Apply one clock edge to both DUT and model, then settle.
  task automatic cyc();
    @(posedge clock);
    if (!ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        if (iv && ir == 5'(i)) m_busy[i] = 1'b1;
        else if (we && wr == 5'(i)) m_busy[i] = 1'b0;
      end
      if (we && wr != 5'd0) m_mem[wr] = wd;
    end
    #1;
  endtask

  initial begin
    model_clear();
    ctrl_reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    check_all("por");
    ctrl_reset = 1'b0;

    // write/read, including r0 write ignored
    drive(1, 3, 32'h12345678, 0, 0, 3, 3);
    cyc();
    drive(0, 0, 0, 0, 0, 3, 3);
    #1 check_all("rw3");
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 3);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 3);
    #1 check_all("rw0");

    // scoreboard set/clear
    drive(0, 0, 0, 1, 4, 4, 9);
    cyc();
    drive(0, 0, 0, 1, 9, 4, 9);
    cyc();
    drive(0, 0, 0, 0, 0, 4, 9);
    #1 check_all("iss2");
    drive(1, 4, 32'h11, 0, 0, 4, 9);
    cyc();
    drive(0, 0, 0, 0, 0, 4, 9);
    #1 check_all("wb4");

    // simultaneous issue + writeback to r4
    drive(0, 0, 0, 1, 4, 4, 9);
    cyc();
    drive(1, 4, 32'hA5A5A5A5, 1, 4, 4, 9);
    cyc();
    drive(0, 0, 0, 0, 0, 4, 9);
    #1 check_all("simul");
    drive(0, 0, 0, 1, 0, 0, 4);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 4);
    #1 check_all("iss0");

    // saturation
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 1, 5'(i), 5'(i), 1);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 31, 1);
    #1 check_all("sat31");
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 5'(i), 2);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 31, 2);
    #1 check_all("sat0");

    // same-cycle write while reading r6
    drive(1, 6, 32'hCAFEF00D, 0, 0, 6, 6);
    #1 check_all("byp.pre");
    cyc();
    drive(0, 0, 0, 0, 0, 6, 6);
    #1 check_all("byp.post");

    // asynchronous reset mid-run
    drive(1, 5, 32'hDEADBEEF, 1, 7, 5, 7);
    cyc();
    drive(0, 0, 0, 0, 0, 5, 7);
    #1 check_all("prerst");
    #1 ctrl_reset = 1'b1;
    #1;
    model_clear();
    check_all("midrst");
    #1 ctrl_reset = 1'b0;
    cyc();
    check_all("postrst");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, 5'($urandom),
            $urandom, $urandom_range(0, 2) != 0,
            5'($urandom), 5'($urandom), 5'($urandom));
      #1 check_all("rnd.pre");
      cyc();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
